// File: rtl/mux_2.sv
// rtl/mux_2.sv - 2:1 select with registered tap and select-toggle statistics
// Optional statistics (j_q, sel_chg, sw_cnt) are built only when MUX2_STATS_EN is defined.
module mux_2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             j,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] sw_cnt
);

  // Conditional operator keeps o defined when i0==i1 even if j is X/Z.
  assign o = j ? i1 : i0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
    end else begin
      o_q <= o;
    end
  end

`ifdef MUX2_STATS_EN
  logic             j_q;
  logic             sel_chg_r;
  logic [CNT_W-1:0] sw_cnt_r;

  // Only values sampled on clk edges are compared, so glitches between edges never count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q       <= 1'b0;
      sel_chg_r <= 1'b0;
      sw_cnt_r  <= '0;
    end else begin
      j_q       <= j;
      sel_chg_r <= (j != j_q);
      if ((j != j_q) && (sw_cnt_r != {CNT_W{1'b1}})) begin
        sw_cnt_r <= sw_cnt_r + CNT_W'(1);
      end
    end
  end

  assign sel_chg = sel_chg_r;
  assign sw_cnt  = sw_cnt_r;
`else
  assign sel_chg = 1'b0;
  assign sw_cnt  = '0;
`endif

endmodule

// File: tb/tb_mux_2.sv
// tb/tb_mux_2.sv - directed self-checking bench for mux_2
// Stats expectations follow MUX2_STATS_EN; without it sel_chg/sw_cnt must stay 0.
module tb_mux_2;

`ifdef MUX2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] i0, i1, o, o_q;
  logic       j;
  logic       sel_chg;
  logic [1:0] sw_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mux_2 #(.WIDTH(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .j(j),
    .o(o), .o_q(o_q), .sel_chg(sel_chg), .sw_cnt(sw_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stats(input string tag, input logic exp_chg, input logic [1:0] exp_cnt);
    check({tag, "_sel_chg"}, {31'd0, sel_chg}, STATS ? {31'd0, exp_chg} : 32'd0);
    check({tag, "_sw_cnt"}, {30'd0, sw_cnt}, STATS ? {30'd0, exp_cnt} : 32'd0);
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step_j(input logic nj);
    @(negedge clk);
    j = nj;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tt;
  logic [2:0] v;
  logic [1:0] exp_cnt;

  initial begin
    tt  = 8'b1101_1000;  // o for (i0,i1,j) = 7..0
    rst = 1'b1;
    i0  = 1'b0;
    i1  = 1'b0;
    j   = 1'b0;
    #1;
    check("rst_o_q", {31'd0, o_q}, 32'd0);
    stats("rst", 1'b0, 2'd0);

    // Truth-table sweep, j changing fastest; o must be valid during reset.
    for (int k = 0; k < 8; k++) begin
      v  = 3'(k);
      i0 = v[2];
      i1 = v[1];
      j  = v[0];
      #100;
      check($sformatf("tt_%0d", k), {31'd0, o}, {31'd0, tt[k]});
    end
    check("sweep_o_q_in_rst", {31'd0, o_q}, 32'd0);

    // Equal inputs: o is defined regardless of j.
    i0 = 1'b1;
    i1 = 1'b1;
    j  = 1'bx;
    #1;
    check("eq_j_x", {31'd0, o}, 32'd1);

    i0 = 1'b1;
    i1 = 1'b0;
    j  = 1'b0;
    #1;
    check("rst_o_imm", {31'd0, o}, 32'd1);
    check("rst_o_q_imm", {31'd0, o_q}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_o_q", {31'd0, o_q}, 32'd1);
    stats("rel", 1'b0, 2'd0);

    // j 0->1->0 on two consecutive edges.
    step_j(1'b1);
    check("t1_o", {31'd0, o}, 32'd0);
    stats("t1", 1'b1, 2'd1);
    step_j(1'b0);
    check("t2_o_q", {31'd0, o_q}, 32'd1);
    stats("t2", 1'b1, 2'd2);
    step_j(1'b0);
    stats("t3_hold", 1'b0, 2'd2);

    // Glitch between edges must not be counted.
    @(negedge clk);
    j = 1'b1;
    #2;
    j = 1'b0;
    @(posedge clk);
    #1;
    stats("glitch", 1'b0, 2'd2);

    // Asynchronous reset mid-count, checked before any clock edge.
    step_j(1'b1);
    stats("pre_arst", 1'b1, 2'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    stats("arst", 1'b0, 2'd0);
    check("arst_o_q", {31'd0, o_q}, 32'd0);
    check("arst_o", {31'd0, o}, 32'd0);

    // j is still 1 on the first edge after reset, so it counts as a toggle.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    stats("first_edge", 1'b1, 2'd1);

    // Saturation at 3 with CNT_W=2.
    exp_cnt = 2'd1;
    for (int k = 0; k < 5; k++) begin
      step_j(~j);
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      stats($sformatf("sat_%0d", k), 1'b1, exp_cnt);
    end
    step_j(j);
    stats("sat_hold", 1'b0, 2'd3);
    step_j(~j);
    stats("sat_nowrap", 1'b1, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
